sqr_pipe: RTL and testbench
===========================

# sqr_pipe

Parametrised, pipelined unsigned squarer: accepts a W-bit operand per cycle over a valid/ready handshake and returns its exact 2W-bit square after a fixed, configurable number of register stages. It is the sequential, width-generic successor to the fixed-width 6-bit combinational squarer. It sits in the arithmetic datapath between an operand source and any consumer that can apply backpressure. An optional compile-time accumulator adds sum-of-squares over framed streams.

## Interface
- W, default 6: operand width in bits; legal range 2..32.
- STAGES, default 3: register stages from input to output; legal range 1..8.
- ACC_W, default 2*W+8: accumulator width; used only when the accumulate feature is compiled in.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand present.
- in_ready  out  1  block accepts the operand this cycle.
- in_data  in  W  unsigned operand.
- in_last  in  1  last operand of a frame; used only with the accumulate feature.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  2W  in_data squared, unsigned, exact.
- out_acc  out  ACC_W  running sum of squares; present only with the accumulate feature.
- out_last  out  1  in_last delayed alongside the result.
- acc_sat  out  1  accumulator has saturated in the current frame; present only with the accumulate feature.

## Operation
- Transfers:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
- Stall and ready:
  - The pipeline uses a single global enable: adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational.
  - When adv=0, every stage register holds, including its valid bit.
- Pipeline contents: each stage carries valid, last and partial data. Stage 0 captures in_valid && in_ready.
- Arithmetic:
  - out_data = in_data * in_data, exact, with no truncation.
  - out_data[1] is always 0.
  - out_data[0] equals in_data[0].
  - Partial-product rows may be distributed across the stages in any way, provided the result is exact for every STAGES value.
- Ordering and loss:
  - No bubbles are inserted.
  - Results emerge in input order.
  - Nothing is dropped or duplicated.
- Reset:
  - All valid bits clear immediately, including mid-stream.
  - Data registers clear to 0.
  - In-flight beats are discarded.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_acc=0, acc_sat=0.
  - in_ready=1, since out_valid=0.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, i.e. STAGES cycles later, provided no stall occurs.
- Throughput: 1 beat per cycle while out_ready=1.
- Backpressure: out_valid, out_data, out_last and out_acc remain stable while out_valid && !out_ready.
- Simultaneous input and output transfer in the same cycle is legal and loses nothing.
- in_ready depends combinationally on out_ready.

## Configuration
- SQR_PIPE_ACC_EN defined:
  - out_acc holds the saturating sum of all squares in the current frame, up to and including the current output beat.
  - The sum restarts from 0 on the beat after one with out_last=1.
  - The accumulator updates only on an output transfer.
  - If the sum would exceed 2^ACC_W-1, out_acc clamps to all-ones and acc_sat goes high. acc_sat clears together with the accumulator.
- SQR_PIPE_ACC_EN undefined:
  - The out_acc and acc_sat ports are absent and there is no accumulator logic.
  - in_last/out_last still pass through the pipeline.

## Structure
- Shared package sqr_pipe_pkg:
  - Function sqr_ref(x), the behavioural golden model.
  - Constants for legal W/STAGES bounds, checked by elaboration assertions.
  - Typedef for the stage payload struct {valid, last, data}.
- Sub-module sqr_pipe_stage:
  - One register stage with enable and async reset.
  - Adds a configurable subset of partial-product rows.
  - Instantiated STAGES times via generate.

## Test plan
- Basics, W=6, STAGES=3:
  - Reset, then in_data=0 → out_data=0 three cycles later.
  - in_data=63 → out_data=3969.
- Stream, W=6, out_ready=1: stream all values 0..63 back-to-back → 64 results in order, each equal to x², no gaps.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → in_ready=0, output held stable, every result still delivered in order.
- Reset mid-stream: assert rst with 3 beats in flight → out_valid=0 at once; after release, the first new input 5 gives 25 with no stale data.
- Sweep: W=16, STAGES=1 and STAGES=8 with random operands versus sqr_ref → all match; in particular 65535 → 4294836225.
- Accumulator, SQR_PIPE_ACC_EN, W=6:
  - Frame 1,2,3 with last on 3 → out_acc = 1, 5, 14.
  - The next frame starts from 0.
  - With ACC_W=12, repeating 63 until the sum passes 4095 → out_acc=4095 and acc_sat=1.

Source files
------------

// File: rtl/sqr_pipe_pkg.sv
// sqr_pipe_pkg: shared stage payload type, legal parameter bounds and the
// behavioural golden model for the pipelined squarer.
package sqr_pipe_pkg;

    localparam int W_MIN      = 2;
    localparam int W_MAX      = 32;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 8;
    localparam int DATA_MAX   = 2 * W_MAX;

    // Sized for the widest legal operand; narrower builds keep the upper
    // data bits at zero so every stage can share one payload type.
    typedef struct packed {
        logic                valid;
        logic                last;
        logic [DATA_MAX-1:0] data;
    } stage_t;

    function automatic logic [DATA_MAX-1:0] sqr_ref(input logic [W_MAX-1:0] x);
        return DATA_MAX'(x) * DATA_MAX'(x);
    endfunction

    // First partial-product row owned by stage s when w rows are spread over
    // n stages; row_lo(n, w, n) == w closes the final range.
    function automatic int row_lo(input int s, input int w, input int n);
        return (s * w) / n;
    endfunction

endpackage

// File: rtl/sqr_pipe_stage.sv
// sqr_pipe_stage: one register stage of the squarer. Adds partial-product rows
// [ROW_LO, ROW_HI) of the carried operand into the running sum.
module sqr_pipe_stage
    import sqr_pipe_pkg::*;
#(
    parameter int W      = 6,
    parameter int ROW_LO = 0,
    parameter int ROW_HI = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  stage_t       pl_i,
    input  logic [W-1:0] x_i,
    output stage_t       pl_o,
    output logic [W-1:0] x_o
);

    stage_t         pl_d, pl_q;
    logic [W-1:0]   x_d, x_q, x_sh;
    logic [2*W-1:0] x_ext, sum;
    logic           unused_hi;

    always_comb begin
        x_ext = {{W{1'b0}}, x_i};
        sum   = pl_i.data[2*W-1:0];
        x_sh  = '0;
        for (int r = ROW_LO; r < ROW_HI; r++) begin
            x_sh = x_i >> r;
            if (x_sh[0]) sum = sum + (x_ext << r);
        end
        pl_d               = '0;
        pl_d.valid         = pl_i.valid;
        pl_d.last          = pl_i.last;
        pl_d.data[2*W-1:0] = sum;
        x_d                = x_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_q <= '0;
            x_q  <= '0;
        end else if (en_i) begin
            pl_q <= pl_d;
            x_q  <= x_d;
        end
    end

    assign pl_o      = pl_q;
    assign x_o       = x_q;
    assign unused_hi = ^pl_i.data;

endmodule

// File: rtl/sqr_pipe.sv
// sqr_pipe: pipelined exact unsigned squarer with valid/ready handshake and a
// single global stall. Optional framed sum-of-squares via SQR_PIPE_ACC_EN.
module sqr_pipe
    import sqr_pipe_pkg::*;
#(
    parameter int W      = 6,
    parameter int STAGES = 3,
    parameter int ACC_W  = 2 * W + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_data,
`ifdef SQR_PIPE_ACC_EN
    output logic [ACC_W-1:0] out_acc,
    output logic             acc_sat,
`endif
    output logic             out_last
);

    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("sqr_pipe: W outside legal range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sqr_pipe: STAGES outside legal range");
    end
    if (ACC_W < 2 * W) begin : g_bad_acc_w
        $error("sqr_pipe: ACC_W narrower than a single square");
    end

    logic                        adv;
    stage_t                      pl_in;
    stage_t [STAGES-1:0]         pl_out;
    logic   [STAGES-1:0][W-1:0]  x_out;
    logic                        unused_tail;

    // Whole pipe moves or holds together; a free output slot frees every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        pl_in       = '0;
        pl_in.valid = in_valid && adv;
        pl_in.last  = in_last;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        stage_t       pl_src;
        logic [W-1:0] x_src;
        if (s == 0) begin : g_head
            assign pl_src = pl_in;
            assign x_src  = in_data;
        end else begin : g_body
            assign pl_src = pl_out[s-1];
            assign x_src  = x_out[s-1];
        end
        sqr_pipe_stage #(
            .W      (W),
            .ROW_LO (row_lo(s, W, STAGES)),
            .ROW_HI (row_lo(s + 1, W, STAGES))
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (adv),
            .pl_i (pl_src),
            .x_i  (x_src),
            .pl_o (pl_out[s]),
            .x_o  (x_out[s])
        );
    end

    assign out_valid   = pl_out[STAGES-1].valid;
    assign out_last    = pl_out[STAGES-1].last;
    assign out_data    = pl_out[STAGES-1].data[2*W-1:0];
    assign unused_tail = ^{pl_out[STAGES-1].data, x_out[STAGES-1]};

`ifdef SQR_PIPE_ACC_EN
    logic [ACC_W-1:0] acc_q, acc_d, acc_cur;
    logic             sat_q, sat_d, sat_cur;
    logic [ACC_W:0]   sq_ext, acc_sum;

    // acc_q holds the frame sum before the beat at the output, so out_acc can
    // include that beat while staying stable under backpressure.
    always_comb begin
        sq_ext             = '0;
        sq_ext[2*W-1:0]    = out_data;
        acc_sum            = {1'b0, acc_q} + sq_ext;
        sat_cur            = sat_q || acc_sum[ACC_W];
        acc_cur            = sat_cur ? '1 : acc_sum[ACC_W-1:0];
        acc_d              = acc_q;
        sat_d              = sat_q;
        if (out_valid && out_ready) begin
            if (out_last) begin
                acc_d = '0;
                sat_d = 1'b0;
            end else begin
                acc_d = acc_cur;
                sat_d = sat_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign out_acc = out_valid ? acc_cur : acc_q;
    assign acc_sat = out_valid ? sat_cur : sat_q;
`endif

endmodule

// File: tb/tb_sqr_pipe.sv
// tb_sqr_pipe: scoreboard bench for sqr_pipe; W=6/STAGES=3 main instance plus
// W=16 instances at STAGES=1 and STAGES=8 fed the same stream.
module tb_sqr_pipe;

    typedef struct packed {
        logic [63:0] exp;
        logic        last;
        int          cyc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [5:0]  a_in_data = '0;
    logic [15:0] w_in_data = '0;
    logic        a_out_ready = 1'b1;
    logic        w_out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_out_last;
    logic [11:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [31:0] b_out_data;
    logic        c_in_ready, c_out_valid, c_out_last;
    logic [31:0] c_out_data;
`ifdef SQR_PIPE_ACC_EN
    logic [11:0] a_out_acc;
    logic [39:0] b_out_acc, c_out_acc;
    logic        a_acc_sat, b_acc_sat, c_acc_sat;
    logic [63:0] m_acc = '0;
    logic        m_sat = 1'b0;
`endif

    ent_t qa[$], qb[$], qc[$];
    int   nchk = 0, nerr = 0, cyc = 0, a_stall = -1000;
    logic a_fired = 1'b0;

    always #5 clk = ~clk;

    sqr_pipe #(.W(6), .STAGES(3), .ACC_W(12)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data),
`ifdef SQR_PIPE_ACC_EN
        .out_acc(a_out_acc), .acc_sat(a_acc_sat),
`endif
        .out_last(a_out_last)
    );

    sqr_pipe #(.W(16), .STAGES(1)) u_w16_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(w_in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(w_out_ready), .out_data(b_out_data),
`ifdef SQR_PIPE_ACC_EN
        .out_acc(b_out_acc), .acc_sat(b_acc_sat),
`endif
        .out_last(b_out_last)
    );

    sqr_pipe #(.W(16), .STAGES(8)) u_w16_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(w_in_data), .in_last(in_last), .out_valid(c_out_valid),
        .out_ready(w_out_ready), .out_data(c_out_data),
`ifdef SQR_PIPE_ACC_EN
        .out_acc(c_out_acc), .acc_sat(c_acc_sat),
`endif
        .out_last(c_out_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation of instance d and compare one output beat.
    task automatic score(input int d, input logic [63:0] got, input logic got_last);
        ent_t  e;
        int    sz, lat;
        string nm;
        nm  = (d == 0) ? "a" : (d == 1) ? "b" : "c";
        sz  = (d == 0) ? qa.size() : (d == 1) ? qb.size() : qc.size();
        lat = (d == 0) ? 3 : (d == 1) ? 1 : 8;
        check({nm, "_expected_beat"}, 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            case (d)
                0:       e = qa.pop_front();
                1:       e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            check({nm, "_data"}, got, e.exp);
            check({nm, "_last"}, 64'(got_last), 64'(e.last));
            if (d != 0 || e.cyc > a_stall)
                check({nm, "_latency"}, 64'(cyc - e.cyc), 64'(lat));
`ifdef SQR_PIPE_ACC_EN
            if (d == 0) begin
                logic [63:0] s, av;
                logic        sat;
                s   = m_acc + e.exp;
                sat = m_sat || (s > 64'd4095);
                av  = sat ? 64'd4095 : s;
                check("a_acc", 64'(a_out_acc), av);
                check("a_acc_sat", 64'(a_acc_sat), 64'(sat));
                m_acc = e.last ? 64'd0 : av;
                m_sat = e.last ? 1'b0 : sat;
            end
`endif
        end
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (!a_out_ready) a_stall = cyc;
        check("a_in_ready", 64'(a_in_ready), 64'(!a_out_valid || a_out_ready));
        if (a_out_valid && !a_out_ready && qa.size() > 0)
            check("a_hold_data", 64'(a_out_data), qa[0].exp);
        if (a_out_valid && a_out_ready) score(0, 64'(a_out_data), a_out_last);
        if (b_out_valid) score(1, 64'(b_out_data), b_out_last);
        if (c_out_valid) score(2, 64'(c_out_data), c_out_last);
        a_fired = in_valid && a_in_ready;
        if (a_fired)
            qa.push_back('{exp: 64'(a_in_data) * 64'(a_in_data), last: in_last, cyc: cyc});
        if (in_valid && b_in_ready)
            qb.push_back('{exp: 64'(w_in_data) * 64'(w_in_data), last: in_last, cyc: cyc});
        if (in_valid && c_in_ready)
            qc.push_back('{exp: 64'(w_in_data) * 64'(w_in_data), last: in_last, cyc: cyc});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic last);
        in_valid  = 1'b1;
        a_in_data = x[5:0];
        w_in_data = x;
        in_last   = last;
        a_fired   = 1'b0;
        for (int t = 0; t < 50 && !a_fired; t++) cycle();
        check("a_accept", 64'(a_fired), 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 200 && (qa.size() + qb.size() + qc.size()) > 0; t++) cycle();
        check("a_drained", 64'(qa.size()), 64'd0);
        check("b_drained", 64'(qb.size()), 64'd0);
        check("c_drained", 64'(qc.size()), 64'd0);
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        qc.delete();
`ifdef SQR_PIPE_ACC_EN
        m_acc = '0;
        m_sat = 1'b0;
`endif
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        clear_model();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int k;
        do_reset();
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_last", 64'(a_out_last), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
`ifdef SQR_PIPE_ACC_EN
        check("rst_out_acc", 64'(a_out_acc), 64'd0);
        check("rst_acc_sat", 64'(a_acc_sat), 64'd0);
`endif

        // Basics: zero, then the largest 6-bit operand.
        send(16'd0, 1'b1);
        drain();
        send(16'd63, 1'b1);
        drain();

        // Back-to-back stream of every 6-bit value.
        for (int x = 0; x < 64; x++) send(16'(x), (x % 8) == 7);
        drain();

        // Five cycles of output backpressure in the middle of a stream.
        k = 0;
        for (int t = 0; t < 60 && k < 12; t++) begin
            in_valid    = 1'b1;
            a_in_data   = 6'(k * 5 + 7);
            w_in_data   = 16'(k * 5 + 7);
            in_last     = (k % 4) == 3;
            a_out_ready = !(t >= 5 && t < 10);
            cycle();
            if (a_fired) k++;
        end
        a_out_ready = 1'b1;
        check("bp_all_sent", 64'(k), 64'd12);
        drain();

        // Reset with beats in flight, then a fresh operand.
        send(16'd20, 1'b0);
        send(16'd21, 1'b0);
        send(16'd22, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_mid_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_mid_a_data", 64'(a_out_data), 64'd0);
        check("rst_mid_b_valid", 64'(b_out_valid), 64'd0);
        check("rst_mid_c_valid", 64'(c_out_valid), 64'd0);
        clear_model();
        cycle();
        cycle();
        rst = 1'b0;
        send(16'd5, 1'b1);
        drain();

        // Random 16-bit sweep including both extremes.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] x;
            x = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h0000 : 16'($urandom);
            send(x, ($urandom_range(0, 4) == 0));
        end
        drain();

`ifdef SQR_PIPE_ACC_EN
        // Framed sums, restart after last, then saturation at ACC_W=12.
        do_reset();
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b1);
        send(16'd4, 1'b1);
        for (int i = 0; i < 3; i++) send(16'd63, i == 2);
        send(16'd2, 1'b1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
